// File: rtl/ff_pkg.sv
// Shared field-arithmetic definitions: constants, op encoding, limb count helper, control states.
package ff_pkg;

    // 2^255 - 19
    localparam logic [254:0] P25519 = {{250{1'b1}}, 5'b01101};

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ff_state_e;

    function automatic int unsigned num_limbs(int unsigned width, int unsigned limb_w);
        return (width + limb_w - 1) / limb_w;
    endfunction

endpackage

// File: rtl/ff_limb_addsub.sv
// One limb of the primary (a +/- b) and correction (s -/+ P) carry chains.
module ff_limb_addsub
    import ff_pkg::*;
#(
    parameter int unsigned LIMB_W = 64
) (
    input  logic [LIMB_W-1:0] a_i,
    input  logic [LIMB_W-1:0] b_i,
    input  logic [LIMB_W-1:0] P_i,
    input  logic              op,
    input  logic              c_in,
    input  logic              d_in,
    output logic [LIMB_W-1:0] s_i,
    output logic [LIMB_W-1:0] t_i,
    output logic              c_out,
    output logic              d_out
);

    logic [LIMB_W:0] w_s_ext;
    logic [LIMB_W:0] w_t_ext;
    logic [LIMB_W:0] w_c_ext;
    logic [LIMB_W:0] w_d_ext;

    assign w_c_ext = {{LIMB_W{1'b0}}, c_in};
    assign w_d_ext = {{LIMB_W{1'b0}}, d_in};

    // Bit LIMB_W of each extended sum is the carry (add form) or borrow (subtract form).
    always_comb begin
        if (op == OP_ADD) begin
            w_s_ext = {1'b0, a_i} + {1'b0, b_i} + w_c_ext;
            w_t_ext = {1'b0, w_s_ext[LIMB_W-1:0]} - {1'b0, P_i} - w_d_ext;
        end else begin
            w_s_ext = {1'b0, a_i} - {1'b0, b_i} - w_c_ext;
            w_t_ext = {1'b0, w_s_ext[LIMB_W-1:0]} + {1'b0, P_i} + w_d_ext;
        end
        s_i   = w_s_ext[LIMB_W-1:0];
        t_i   = w_t_ext[LIMB_W-1:0];
        c_out = w_s_ext[LIMB_W];
        d_out = w_t_ext[LIMB_W];
    end

endmodule

// File: rtl/ff_addsub_serial.sv
// Limb-serial modular add/subtract over a prime field with valid/ready on both sides.
module ff_addsub_serial
    import ff_pkg::*;
#(
    parameter int unsigned      WIDTH   = 255,
    parameter int unsigned      LIMB_W  = 64,
    parameter logic [WIDTH-1:0] MODULUS = WIDTH'(P25519)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned NUM_LIMBS = num_limbs(WIDTH, LIMB_W);
    localparam int unsigned PW        = NUM_LIMBS * LIMB_W;
    localparam int unsigned CW        = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

    ff_state_e        r_state;
    logic             r_op;
    logic [PW-1:0]    r_a;
    logic [PW-1:0]    r_b;
    logic [PW-1:0]    r_p;
    logic [PW-1:0]    r_s;
    logic [PW-1:0]    r_t;
    logic             r_c;
    logic             r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;

    logic [LIMB_W-1:0] w_s_limb;
    logic [LIMB_W-1:0] w_t_limb;
    logic              w_c;
    logic              w_d;
    logic [PW-1:0]     w_s_next;
    logic [PW-1:0]     w_t_next;
    logic              w_sel_t;

    ff_limb_addsub #(
        .LIMB_W(LIMB_W)
    ) u_limb (
        .a_i  (r_a[LIMB_W-1:0]),
        .b_i  (r_b[LIMB_W-1:0]),
        .P_i  (r_p[LIMB_W-1:0]),
        .op   (r_op),
        .c_in (r_c),
        .d_in (r_d),
        .s_i  (w_s_limb),
        .t_i  (w_t_limb),
        .c_out(w_c),
        .d_out(w_d)
    );

    // New limb enters at the top so the LSB limb ends up at bit 0 after NUM_LIMBS shifts.
    always_comb begin
        w_s_next = (r_s >> LIMB_W) | (PW'(w_s_limb) << (PW - LIMB_W));
        w_t_next = (r_t >> LIMB_W) | (PW'(w_t_limb) << (PW - LIMB_W));
        // add: a+b overflowed or a+b-P did not borrow -> reduced value; sub: a<b -> add P back
        w_sel_t  = (r_op == OP_ADD) ? (w_c | ~w_d) : w_c;
    end

    // Control FSM, operand shifters, carry registers and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_p         <= '0;
            r_s         <= '0;
            r_t         <= '0;
            r_c         <= 1'b0;
            r_d         <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op    <= op;
                        r_a     <= PW'(a);
                        r_b     <= PW'(b);
                        r_p     <= PW'(MODULUS);
                        r_c     <= 1'b0;
                        r_d     <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> LIMB_W;
                    r_b   <= r_b >> LIMB_W;
                    r_p   <= r_p >> LIMB_W;
                    r_s   <= w_s_next;
                    r_t   <= w_t_next;
                    r_c   <= w_c;
                    r_d   <= w_d;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(NUM_LIMBS - 1)) begin
                        r_result    <= w_sel_t ? w_t_next[WIDTH-1:0] : w_s_next[WIDTH-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Ready is held low during the reset cycle itself.
    assign in_ready  = (r_state == IDLE) & ~rst;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule

// File: tb/tb_ff_addsub_serial.sv
// Scoreboard bench: default, small (8b/3b limbs, P=251) and single-limb instances.
module tb_ff_addsub_serial;
    import ff_pkg::*;

    localparam logic [254:0] P  = P25519;
    localparam logic [7:0]   PS = 8'd251;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] ref_op(input logic o, input logic [255:0] x,
                                            input logic [255:0] y, input logic [255:0] p);
        logic [256:0] s;
        if (o == OP_ADD) begin
            s = x + y;
            if (s >= p) s = s - p;
        end else begin
            if (x >= y) s = x - y;
            else        s = x + p - y;
        end
        return s[255:0];
    endfunction

    // ---------------- default instance ----------------
    logic         d_in_valid = 0, d_in_ready, d_op = 0, d_out_valid, d_out_ready = 1;
    logic [254:0] d_a = '0, d_b = '0, d_result;
    logic [255:0] d_q[$];
    int unsigned  d_acc = 0;
    bit           d_prev = 0;

    ff_addsub_serial u_dut (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .op(d_op),
        .a(d_a), .b(d_b), .out_valid(d_out_valid), .out_ready(d_out_ready), .result(d_result)
    );

    // ---------------- small instance ----------------
    logic       s_in_valid = 0, s_in_ready, s_op = 0, s_out_valid, s_out_ready = 1;
    logic [7:0] s_a = '0, s_b = '0, s_result;
    logic [255:0] s_q[$];
    int unsigned  s_acc = 0;
    bit           s_prev = 0;

    ff_addsub_serial #(.WIDTH(8), .LIMB_W(3), .MODULUS(PS)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
        .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result)
    );

    // ---------------- single-limb instance ----------------
    logic         w_in_valid = 0, w_in_ready, w_op = 0, w_out_valid, w_out_ready = 1;
    logic [254:0] w_a = '0, w_b = '0, w_result;
    logic [255:0] w_q[$];
    int unsigned  w_acc = 0;
    bit           w_prev = 0;

    ff_addsub_serial #(.WIDTH(255), .LIMB_W(255)) u_wide (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
        .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result)
    );

    // Output monitors: latency on rising out_valid, scoreboard pop on each transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (d_out_valid && !d_prev) chk("d_latency", cyc - d_acc, 4);
            if (d_out_valid && d_out_ready) begin
                if (d_q.size() == 0) chk("d_spurious", 1, 0);
                else chk("d_result", d_result, d_q.pop_front());
            end
            if (s_out_valid && !s_prev) chk("s_latency", cyc - s_acc, 3);
            if (s_out_valid && s_out_ready) begin
                if (s_q.size() == 0) chk("s_spurious", 1, 0);
                else chk("s_result", s_result, s_q.pop_front());
            end
            if (w_out_valid && !w_prev) chk("w_latency", cyc - w_acc, 1);
            if (w_out_valid && w_out_ready) begin
                if (w_q.size() == 0) chk("w_spurious", 1, 0);
                else chk("w_result", w_result, w_q.pop_front());
            end
        end
        d_prev = d_out_valid;
        s_prev = s_out_valid;
        w_prev = w_out_valid;
    end

    task automatic d_issue(input logic o, input logic [254:0] x, input logic [254:0] y,
                           input bit push);
        int n = 0;
        @(posedge clk); #1;
        while (!d_in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!d_in_ready) chk("d_ready_timeout", 0, 1);
        d_op = o; d_a = x; d_b = y; d_in_valid = 1;
        if (push) d_q.push_back(ref_op(o, x, y, P));
        @(posedge clk); #1;
        d_acc = cyc;
        d_in_valid = 0;
    endtask

    task automatic s_issue(input logic o, input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        @(posedge clk); #1;
        while (!s_in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!s_in_ready) chk("s_ready_timeout", 0, 1);
        s_op = o; s_a = x; s_b = y; s_in_valid = 1;
        s_q.push_back(ref_op(o, x, y, PS));
        @(posedge clk); #1;
        s_acc = cyc;
        s_in_valid = 0;
    endtask

    task automatic w_issue(input logic o, input logic [254:0] x, input logic [254:0] y);
        int n = 0;
        @(posedge clk); #1;
        while (!w_in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!w_in_ready) chk("w_ready_timeout", 0, 1);
        w_op = o; w_a = x; w_b = y; w_in_valid = 1;
        w_q.push_back(ref_op(o, x, y, P));
        @(posedge clk); #1;
        w_acc = cyc;
        w_in_valid = 0;
    endtask

    task automatic d_wait_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!d_out_valid && n < 100) begin @(negedge clk); n++; end
        if (!d_out_valid) chk(tag, 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((d_q.size() + s_q.size() + w_q.size()) != 0 && n < 200) begin
            @(negedge clk); n++;
        end
        chk("drain_empty", d_q.size() + s_q.size() + w_q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    logic [254:0] held;
    logic [7:0]   bv;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", d_in_ready, 0);
        chk("rst_out_valid", d_out_valid, 0);
        chk("rst_result", d_result, 0);
        rst = 0;
        #1;
        chk("post_rst_in_ready", d_in_ready, 1);

        // Basic sub, then ready returns the cycle after the single-cycle out_valid
        d_issue(OP_SUB, 255'd20, 255'd10, 1);
        d_wait_valid("basic_timeout");
        @(posedge clk); #1;
        chk("basic_ready_back", d_in_ready, 1);
        chk("basic_valid_drop", d_out_valid, 0);

        d_issue(OP_SUB, 255'd1, 255'd2, 1);
        d_issue(OP_SUB, 255'd1 << 254, 255'd1, 1);
        d_issue(OP_ADD, P - 255'd1, 255'd1, 1);
        d_issue(OP_ADD, P - 255'd1, P - 255'd1, 1);
        d_issue(OP_ADD, 255'd0, 255'd0, 1);
        d_issue(OP_ADD, 255'd19, P - 255'd19, 1);
        d_issue(OP_SUB, P - 255'd1, 255'd0, 1);
        drain();

        // Backpressure: result held, ready low, extra in_valid ignored
        d_out_ready = 0;
        d_issue(OP_ADD, 255'd7, 255'd9, 1);
        d_wait_valid("bp_timeout");
        held = d_result;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("bp_stable", d_result, held);
            chk("bp_valid", d_out_valid, 1);
            chk("bp_in_ready", d_in_ready, 0);
            if (i == 2) begin d_in_valid = 1; d_op = OP_ADD; d_a = 255'd3; d_b = 255'd4; end
            if (i == 3) d_in_valid = 0;
        end
        d_out_ready = 1;
        @(posedge clk); #1;
        chk("bp_valid_drop", d_out_valid, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("bp_no_extra", d_out_valid, 0);
        chk("bp_idle", d_in_ready, 1);

        // Reset in the second RUN cycle aborts the op
        d_issue(OP_ADD, 255'd1, 255'd2, 0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chk("mid_rst_valid", d_out_valid, 0);
        chk("mid_rst_result", d_result, 0);
        chk("mid_rst_in_ready", d_in_ready, 0);
        rst = 0;
        #1;
        chk("mid_rst_ready_after", d_in_ready, 1);
        d_issue(OP_SUB, 255'd5, 255'd7, 1);
        drain();

        // Small field: all a, several b per a, both ops
        for (int x = 0; x < 251; x++) begin
            for (int k = 0; k < 4; k++) begin
                case (k)
                    0: bv = 8'd0;
                    1: bv = 8'd250;
                    2: bv = 8'(x);
                    default: bv = 8'($urandom_range(250));
                endcase
                s_issue(OP_ADD, 8'(x), bv);
                s_issue(OP_SUB, 8'(x), bv);
            end
        end
        drain();

        // Single limb
        w_issue(OP_SUB, 255'd20, 255'd10);
        w_issue(OP_SUB, 255'd1, 255'd2);
        w_issue(OP_ADD, P - 255'd1, P - 255'd1);
        w_issue(OP_ADD, 255'd19, P - 255'd19);
        w_issue(OP_SUB, 255'd1 << 254, 255'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
